// File: rtl/axi_mem_responder.sv
// -----------------------------------------------------------------------------
// axi_mem_responder
//   AXI-style memory slave for the core's single external AXI port. It is the
//   memory model for core-level benches and the FPGA on-chip memory.
//   Write bursts (AW/W) are stored into an internal word array and acknowledged
//   with a B response. Read bursts (AR) are answered with R beats taken from the
//   same array. The write path and the read path are two independent FSMs that
//   run concurrently and share only the array.
//
// Parameters
//   ADDR_WIDTH   : AWADDR/ARADDR width (word addresses)
//   DATA_WIDTH   : WDATA/RDATA width
//   DEPTH_LOG2   : array holds 2**DEPTH_LOG2 words, index = addr[DEPTH_LOG2-1:0]
//   READ_LATENCY : wait cycles between the AR handshake and the first R beat (0..15)
//
// Ports
//   clk, rst                       : clock, asynchronous active-high reset
//   AWVALID/AWREADY/AWID/AWLEN/AWADDR : write address channel
//   WVALID/WREADY/WLAST/WID/WDATA  : write data channel (WLAST checked, WID ignored)
//   BVALID/BREADY/BID              : write response channel
//   ARVALID/ARREADY/ARID/ARLEN/ARADDR : read address channel
//   RVALID/RREADY/RLAST/RID/RDATA  : read data channel
//   err_wlast                      : sticky flag, WLAST seen out of place
//
// Every output is a register. Upper address bits above DEPTH_LOG2 are ignored,
// so addresses alias, and bursts wrap modulo the array size.
// -----------------------------------------------------------------------------
module axi_mem_responder #(
   parameter int ADDR_WIDTH   = 26,
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH_LOG2   = 14,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   // write address channel
   input  logic                  AWVALID,
   output logic                  AWREADY,
   input  logic [3:0]            AWID,
   input  logic [3:0]            AWLEN,
   input  logic [ADDR_WIDTH-1:0] AWADDR,
   // write data channel
   input  logic                  WVALID,
   output logic                  WREADY,
   input  logic                  WLAST,
   input  logic [3:0]            WID,
   input  logic [DATA_WIDTH-1:0] WDATA,
   // write response channel
   output logic                  BVALID,
   input  logic                  BREADY,
   output logic [3:0]            BID,
   // read address channel
   input  logic                  ARVALID,
   output logic                  ARREADY,
   input  logic [3:0]            ARID,
   input  logic [3:0]            ARLEN,
   input  logic [ADDR_WIDTH-1:0] ARADDR,
   // read data channel
   output logic                  RVALID,
   input  logic                  RREADY,
   output logic                  RLAST,
   output logic [3:0]            RID,
   output logic [DATA_WIDTH-1:0] RDATA,
   // status
   output logic                  err_wlast
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] IDX_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
   localparam logic [3:0]            LAT_INIT = 4'(READ_LATENCY);

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } w_state_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_DATA = 2'd2
   } r_state_t;

   // word array, deliberately never cleared
   logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

   // ---------------- write path state ----------------
   w_state_t              w_state_r, w_state_s;
   logic [3:0]            w_id_r,    w_id_s;
   logic [3:0]            w_len_r,   w_len_s;
   logic [3:0]            w_cnt_r,   w_cnt_s;
   logic [DEPTH_LOG2-1:0] w_idx_r,   w_idx_s;
   logic                  err_wlast_r, err_wlast_s;
   logic                  awready_r, wready_r, bvalid_r;
   logic [3:0]            bid_r;
   logic                  mem_we_s;

   // ---------------- read path state ----------------
   r_state_t              r_state_r, r_state_s;
   logic [3:0]            r_id_r,    r_id_s;
   logic [3:0]            r_len_r,   r_len_s;
   logic [3:0]            r_cnt_r,   r_cnt_s;
   logic [3:0]            r_lat_r,   r_lat_s;
   logic [DEPTH_LOG2-1:0] r_idx_r,   r_idx_s;
   logic                  arready_r, rvalid_r, rlast_r;
   logic [3:0]            rid_r;
   logic [DATA_WIDTH-1:0] rdata_r;
   logic                  rd_load_s;
   logic [DEPTH_LOG2-1:0] rd_idx_s;

   // WID and the aliased upper address bits carry no information here
   logic unused_s;
   assign unused_s = ^{WID, AWADDR[ADDR_WIDTH-1:DEPTH_LOG2], ARADDR[ADDR_WIDTH-1:DEPTH_LOG2]};

   assign AWREADY   = awready_r;
   assign WREADY    = wready_r;
   assign BVALID    = bvalid_r;
   assign BID       = bid_r;
   assign ARREADY   = arready_r;
   assign RVALID    = rvalid_r;
   assign RLAST     = rlast_r;
   assign RID       = rid_r;
   assign RDATA     = rdata_r;
   assign err_wlast = err_wlast_r;

   // Write FSM next-state logic, array write enable and WLAST checking
   always_comb begin
      w_state_s   = w_state_r;
      w_id_s      = w_id_r;
      w_len_s     = w_len_r;
      w_cnt_s     = w_cnt_r;
      w_idx_s     = w_idx_r;
      err_wlast_s = err_wlast_r;
      mem_we_s    = 1'b0;
      case (w_state_r)
         W_IDLE: begin
            // the handshake uses the registered READY, so nothing is taken
            // in the first cycle after reset while AWREADY is still low
            if (AWVALID && awready_r) begin
               w_state_s = W_DATA;
               w_id_s    = AWID;
               w_len_s   = AWLEN;
               w_idx_s   = AWADDR[DEPTH_LOG2-1:0];
               w_cnt_s   = 4'd0;
            end else begin
               w_state_s = W_IDLE;
            end
         end
         W_DATA: begin
            if (WVALID && wready_r) begin
               mem_we_s = 1'b1;
               w_idx_s  = w_idx_r + IDX_ONE;
               w_cnt_s  = w_cnt_r + 4'd1;
               if (WLAST != (w_cnt_r == w_len_r)) begin
                  err_wlast_s = 1'b1;
               end else begin
                  err_wlast_s = err_wlast_r;
               end
               // the beat count from AWLEN alone decides where the burst ends
               if (w_cnt_r == w_len_r) begin
                  w_state_s = W_RESP;
               end else begin
                  w_state_s = W_DATA;
               end
            end else begin
               w_state_s = W_DATA;
            end
         end
         W_RESP: begin
            if (BREADY && bvalid_r) begin
               w_state_s = W_IDLE;
            end else begin
               w_state_s = W_RESP;
            end
         end
         default: begin
            w_state_s = W_IDLE;
         end
      endcase
   end

   // Write FSM state and registered write-channel outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state_r   <= W_IDLE;
         w_id_r      <= 4'd0;
         w_len_r     <= 4'd0;
         w_cnt_r     <= 4'd0;
         w_idx_r     <= {DEPTH_LOG2{1'b0}};
         err_wlast_r <= 1'b0;
         awready_r   <= 1'b0;
         wready_r    <= 1'b0;
         bvalid_r    <= 1'b0;
         bid_r       <= 4'd0;
      end else begin
         w_state_r   <= w_state_s;
         w_id_r      <= w_id_s;
         w_len_r     <= w_len_s;
         w_cnt_r     <= w_cnt_s;
         w_idx_r     <= w_idx_s;
         err_wlast_r <= err_wlast_s;
         // outputs are decoded from the next state so they line up with it
         awready_r   <= (w_state_s == W_IDLE);
         wready_r    <= (w_state_s == W_DATA);
         bvalid_r    <= (w_state_s == W_RESP);
         bid_r       <= w_id_s;
      end
   end

   // Array write port; a same-edge read of this word still sees the old value
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[w_idx_r] <= WDATA;
      end
   end

   // Read FSM next-state logic and RDATA load control
   always_comb begin
      r_state_s = r_state_r;
      r_id_s    = r_id_r;
      r_len_s   = r_len_r;
      r_cnt_s   = r_cnt_r;
      r_lat_s   = r_lat_r;
      r_idx_s   = r_idx_r;
      rd_load_s = 1'b0;
      rd_idx_s  = r_idx_r;
      case (r_state_r)
         R_IDLE: begin
            if (ARVALID && arready_r) begin
               // even with zero latency one wait edge remains: the array read
               // is synchronous and lands in RDATA on the R_DATA entry edge
               r_state_s = R_WAIT;
               r_id_s    = ARID;
               r_len_s   = ARLEN;
               r_idx_s   = ARADDR[DEPTH_LOG2-1:0];
               r_cnt_s   = 4'd0;
               r_lat_s   = LAT_INIT;
            end else begin
               r_state_s = R_IDLE;
            end
         end
         R_WAIT: begin
            if (r_lat_r == 4'd0) begin
               r_state_s = R_DATA;
               rd_load_s = 1'b1;
               rd_idx_s  = r_idx_r;
            end else begin
               r_state_s = R_WAIT;
               r_lat_s   = r_lat_r - 4'd1;
            end
         end
         R_DATA: begin
            if (RREADY && rvalid_r) begin
               if (r_cnt_r == r_len_r) begin
                  r_state_s = R_IDLE;
               end else begin
                  // prefetch the next word on the handshake edge: no bubble
                  r_state_s = R_DATA;
                  r_idx_s   = r_idx_r + IDX_ONE;
                  r_cnt_s   = r_cnt_r + 4'd1;
                  rd_load_s = 1'b1;
                  rd_idx_s  = r_idx_r + IDX_ONE;
               end
            end else begin
               r_state_s = R_DATA;
            end
         end
         default: begin
            r_state_s = R_IDLE;
         end
      endcase
   end

   // Read FSM state and registered read-channel outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state_r <= R_IDLE;
         r_id_r    <= 4'd0;
         r_len_r   <= 4'd0;
         r_cnt_r   <= 4'd0;
         r_lat_r   <= 4'd0;
         r_idx_r   <= {DEPTH_LOG2{1'b0}};
         arready_r <= 1'b0;
         rvalid_r  <= 1'b0;
         rlast_r   <= 1'b0;
         rid_r     <= 4'd0;
         rdata_r   <= {DATA_WIDTH{1'b0}};
      end else begin
         r_state_r <= r_state_s;
         r_id_r    <= r_id_s;
         r_len_r   <= r_len_s;
         r_cnt_r   <= r_cnt_s;
         r_lat_r   <= r_lat_s;
         r_idx_r   <= r_idx_s;
         arready_r <= (r_state_s == R_IDLE);
         rvalid_r  <= (r_state_s == R_DATA);
         rlast_r   <= (r_state_s == R_DATA) && (r_cnt_s == r_len_s);
         rid_r     <= r_id_s;
         // RDATA only changes on a load, so it holds while the beat is stalled
         if (rd_load_s) begin
            rdata_r <= mem_r[rd_idx_s];
         end else begin
            rdata_r <= rdata_r;
         end
      end
   end

endmodule

// File: tb/tb_axi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_axi_mem_responder
//   Directed bench for axi_mem_responder with default parameters
//   (DEPTH_LOG2=14, READ_LATENCY=2). A table of write/read bursts with
//   hand-computed expectations is applied in a loop; short hand-written
//   sequences cover reset, a stalled read, WLAST errors and reset mid-burst.
// -----------------------------------------------------------------------------
module tb_axi_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        AWVALID, AWREADY;
   logic [3:0]  AWID, AWLEN;
   logic [25:0] AWADDR;
   logic        WVALID, WREADY, WLAST;
   logic [3:0]  WID;
   logic [31:0] WDATA;
   logic        BVALID, BREADY;
   logic [3:0]  BID;
   logic        ARVALID, ARREADY;
   logic [3:0]  ARID, ARLEN;
   logic [25:0] ARADDR;
   logic        RVALID, RREADY, RLAST;
   logic [3:0]  RID;
   logic [31:0] RDATA;
   logic        err_wlast;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   axi_mem_responder dut (
      .clk(clk), .rst(rst),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWLEN(AWLEN), .AWADDR(AWADDR),
      .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WID(WID), .WDATA(WDATA),
      .BVALID(BVALID), .BREADY(BREADY), .BID(BID),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
      .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
      .err_wlast(err_wlast)
   );

   typedef struct {
      bit          is_wr;
      logic [3:0]  id;
      logic [3:0]  len;
      logic [25:0] addr;
      logic [31:0] data0;   // write: first word written; read: first word expected
      logic [3:0]  exp_id;  // expected BID / RID
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic sig(input int w);
      case (w)
         0: return AWREADY;
         1: return WREADY;
         2: return BVALID;
         3: return ARREADY;
         4: return RVALID;
         default: return 1'b0;
      endcase
   endfunction

   // wait (sampling on negedges) for a DUT signal, bounded
   task automatic wait_for(input int w, input string name);
      int n = 0;
      while (sig(w) !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (sig(w) !== 1'b1) begin
         tests_run++;
         tests_failed++;
         $display("FAIL timeout %s: got 0 expected 1", name);
      end
   endtask

   task automatic do_write(input logic [3:0] id, input logic [3:0] len, input logic [25:0] addr,
                           input logic [31:0] base, input logic [3:0] exp_bid, input bit bad_wlast);
      @(negedge clk);
      AWVALID = 1'b1; AWID = id; AWLEN = len; AWADDR = addr;
      wait_for(0, "awready");
      @(negedge clk);
      AWVALID = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         WVALID = 1'b1;
         WDATA  = base + 32'(i);
         WID    = id;
         WLAST  = bad_wlast ? (i == 0) : (i == int'(len));
         wait_for(1, "wready");
         @(negedge clk);
      end
      WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
      wait_for(2, "bvalid");
      chk("bid", {28'd0, BID}, {28'd0, exp_bid});
      @(negedge clk);
      BREADY = 1'b0;
      chk("bvalid_drop", {31'd0, BVALID}, 32'd0);
      chk("awready_back", {31'd0, AWREADY}, 32'd1);
   endtask

   task automatic do_read(input logic [3:0] id, input logic [3:0] len, input logic [25:0] addr,
                          input logic [31:0] exp0, input logic [3:0] exp_rid, input bit stall);
      int zeros = 0;
      @(negedge clk);
      ARVALID = 1'b1; ARID = id; ARLEN = len; ARADDR = addr;
      wait_for(3, "arready");
      @(negedge clk);
      ARVALID = 1'b0;
      // cycles with RVALID low after the AR edge: READ_LATENCY + 1
      while (RVALID !== 1'b1 && zeros < 40) begin
         zeros++;
         @(negedge clk);
      end
      chk("rd_latency", 32'(zeros), 32'd3);
      for (int i = 0; i <= int'(len); i++) begin
         chk("rvalid", {31'd0, RVALID}, 32'd1);
         chk("rdata", RDATA, exp0 + 32'(i));
         chk("rid", {28'd0, RID}, {28'd0, exp_rid});
         chk("rlast", {31'd0, RLAST}, (i == int'(len)) ? 32'd1 : 32'd0);
         if (stall && i == 0) begin
            repeat (3) begin
               @(negedge clk);
               chk("stall_rvalid", {31'd0, RVALID}, 32'd1);
               chk("stall_rdata", RDATA, exp0);
            end
         end
         RREADY = 1'b1;
         @(negedge clk);
         RREADY = 1'b0;
      end
      chk("rvalid_end", {31'd0, RVALID}, 32'd0);
      chk("arready_back", {31'd0, ARREADY}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b1, 4'd3,  4'd3,  26'h10,    32'hA0,   4'd3};
      vecs[1] = '{1'b0, 4'd5,  4'd3,  26'h10,    32'hA0,   4'd5};
      vecs[2] = '{1'b1, 4'd7,  4'd0,  26'h20,    32'h55,   4'd7};
      vecs[3] = '{1'b0, 4'd1,  4'd0,  26'h20,    32'h55,   4'd1};
      vecs[4] = '{1'b1, 4'd2,  4'd1,  26'h3FFF,  32'hC0,   4'd2};   // wraps to index 0
      vecs[5] = '{1'b0, 4'd4,  4'd1,  26'h3FFF,  32'hC0,   4'd4};   // reads C0, C1
      vecs[6] = '{1'b0, 4'd6,  4'd0,  26'h4000,  32'hC1,   4'd6};   // alias of index 0
      vecs[7] = '{1'b0, 4'd9,  4'd3,  26'h10010, 32'hA0,   4'd9};   // alias of 0x10
      vecs[8] = '{1'b1, 4'd15, 4'd15, 26'h100,   32'h1000, 4'd15};
      vecs[9] = '{1'b0, 4'd14, 4'd15, 26'h100,   32'h1000, 4'd14};

      rst = 1'b1;
      AWVALID = 1'b0; AWID = 4'd0; AWLEN = 4'd0; AWADDR = 26'd0;
      WVALID = 1'b0; WLAST = 1'b0; WID = 4'd0; WDATA = 32'd0; BREADY = 1'b0;
      ARVALID = 1'b0; ARID = 4'd0; ARLEN = 4'd0; ARADDR = 26'd0; RREADY = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_awready", {31'd0, AWREADY}, 32'd0);
      chk("rst_arready", {31'd0, ARREADY}, 32'd0);
      chk("rst_bvalid",  {31'd0, BVALID},  32'd0);
      chk("rst_rvalid",  {31'd0, RVALID},  32'd0);
      chk("rst_err",     {31'd0, err_wlast}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_awready", {31'd0, AWREADY}, 32'd1);
      chk("post_arready", {31'd0, ARREADY}, 32'd1);
      chk("post_bvalid",  {31'd0, BVALID},  32'd0);
      chk("post_rvalid",  {31'd0, RVALID},  32'd0);

      // table of bursts
      for (int v = 0; v < 10; v++) begin
         if (vecs[v].is_wr)
            do_write(vecs[v].id, vecs[v].len, vecs[v].addr, vecs[v].data0, vecs[v].exp_id, 1'b0);
         else
            do_read(vecs[v].id, vecs[v].len, vecs[v].addr, vecs[v].data0, vecs[v].exp_id, 1'b0);
      end
      chk("err_clean", {31'd0, err_wlast}, 32'd0);

      // stalled first beat: RDATA must hold, no beat skipped
      do_read(4'd10, 4'd3, 26'h10, 32'hA0, 4'd10, 1'b1);

      // WLAST on the first beat of a 3-beat burst; burst still runs 3 beats
      do_write(4'd8, 4'd2, 26'h200, 32'hE0, 4'd8, 1'b1);
      chk("err_set", {31'd0, err_wlast}, 32'd1);
      do_read(4'd8, 4'd2, 26'h200, 32'hE0, 4'd8, 1'b0);
      do_write(4'd1, 4'd0, 26'h300, 32'h77, 4'd1, 1'b0);
      chk("err_sticky", {31'd0, err_wlast}, 32'd1);

      // reset in the middle of a len=7 read burst
      @(negedge clk);
      ARVALID = 1'b1; ARID = 4'd11; ARLEN = 4'd7; ARADDR = 26'h100;
      wait_for(3, "arready_mid");
      @(negedge clk);
      ARVALID = 1'b0;
      wait_for(4, "rvalid_mid");
      RREADY = 1'b1;
      repeat (2) @(negedge clk);
      RREADY = 1'b0;
      chk("mid_rvalid", {31'd0, RVALID}, 32'd1);
      chk("mid_rdata", RDATA, 32'h1002);
      rst = 1'b1;
      #1;
      chk("mid_rst_rvalid", {31'd0, RVALID}, 32'd0);
      chk("mid_rst_err", {31'd0, err_wlast}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_arready", {31'd0, ARREADY}, 32'd1);
      chk("mid_rvalid_idle", {31'd0, RVALID}, 32'd0);
      do_read(4'd12, 4'd3, 26'h100, 32'h1000, 4'd12, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
